// File: rtl/stopwatch_fsm.sv
// Stopwatch controller: synchronises the divided slow clock into a one-cycle
// tick, gates it through a start/stop/clear FSM and counts it on a
// NUM_DIGITS-digit BCD up-counter that feeds the 7-segment display stage.
module stopwatch_fsm #(
  parameter int NUM_DIGITS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    slow_clk,
  input  logic                    btn_start,
  input  logic                    btn_stop,
  input  logic                    btn_clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic [1:0]              state,
  output logic                    wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync_prev;
  logic                    tick_q;
  logic                    start_prev;
  logic                    stop_prev;
  logic                    clear_prev;
  logic                    start_press;
  logic                    stop_press;
  logic                    clear_press;
  logic                    count_en;
  logic [4*NUM_DIGITS-1:0] digits_inc;
  logic                    all_nines;

  // slow_clk is only data here: sync chain plus a registered rising-edge tick;
  // history resets high so a level already high at reset makes no tick
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '1;
      sync_prev <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      sync_prev <= sync_q[SYNC_STAGES-1];
      tick_q    <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  // button level history for single-cycle press detection; held buttons press once
  always_ff @(posedge clk) begin
    if (reset) begin
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      clear_prev <= 1'b1;
    end else begin
      start_prev <= btn_start;
      stop_prev  <= btn_stop;
      clear_prev <= btn_clear;
    end
  end

  assign start_press = btn_start & ~start_prev;
  assign stop_press  = btn_stop  & ~stop_prev;
  assign clear_press = btn_clear & ~clear_prev;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state: clear beats stop beats start; unused code falls back to IDLE
  always_comb begin
    state_d = state_q;
    if (clear_press) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_press) state_d = RUN;
        RUN:     if (stop_press)  state_d = PAUSE;
        PAUSE:   if (start_press) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // BCD increment: ripple the carry through the digits, 9 rolls to 0
  always_comb begin
    logic       carry;
    logic [3:0] d;
    digits_inc = digits;
    carry      = 1'b1;
    d          = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = digits[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          digits_inc[4*i +: 4] = 4'd0;
        end else begin
          digits_inc[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  // counting uses the current state, so a tick alongside stop still counts
  assign count_en = tick_q && (state_q == RUN);

  // count register and wrap pulse; clear wins over a simultaneous tick
  always_ff @(posedge clk) begin
    if (reset) begin
      digits <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear_press) begin
        digits <= '0;
      end else if (count_en) begin
        digits <= digits_inc;
        wrap   <= all_nines;
      end
    end
  end

  assign state   = state_q;
  assign running = (state_q == RUN);

endmodule
